// File: rtl/sine_voice_mixer_if.sv
// rtl/sine_voice_mixer_if.sv - phase/gate inputs and mixed-sample outputs of the voice mixer
interface sine_voice_mixer_if #(
    parameter int NUM_VOICES   = 24,
    parameter int PHASE_WIDTH  = 32,
    parameter int SAMPLE_WIDTH = 16
);
    logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0] phase_value_in;
    logic [NUM_VOICES-1:0]                  gate_in;
    logic                                   sample_tick_in;
    logic signed [SAMPLE_WIDTH-1:0]         mix_out;
    logic                                   mix_valid_out;
    logic                                   busy_out;
    logic                                   overrun_out;

    modport master (
        output phase_value_in, gate_in, sample_tick_in,
        input  mix_out, mix_valid_out, busy_out, overrun_out
    );

    modport slave (
        input  phase_value_in, gate_in, sample_tick_in,
        output mix_out, mix_valid_out, busy_out, overrun_out
    );
endinterface

// File: rtl/sine_voice_mixer.sv
// rtl/sine_voice_mixer.sv - walks snapshotted voice phases through one shared sine ROM and mixes gated voices
module sine_voice_mixer #(
    parameter int NUM_VOICES     = 24,
    parameter int PHASE_WIDTH    = 32,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int MIX_SHIFT      = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    sine_voice_mixer_if.slave bus
);
    localparam int ROM_DEPTH = 2 ** LUT_ADDR_WIDTH;
    localparam int IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W     = SAMPLE_WIDTH + $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (SAMPLE_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(2 ** (SAMPLE_WIDTH - 1)));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    function automatic logic signed [SAMPLE_WIDTH-1:0] sine_entry(input int k);
        real amp;
        real ang;
        real val;
        int  r;
        amp = real'((2 ** (SAMPLE_WIDTH - 1)) - 1);
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(ROM_DEPTH);
        val = amp * $sin(ang);
        r   = (val >= 0.0) ? $rtoi(val + 0.5) : -$rtoi(0.5 - val);
        return SAMPLE_WIDTH'(r);
    endfunction

    logic signed [SAMPLE_WIDTH-1:0] rom_w [ROM_DEPTH];
    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        assign rom_w[k] = sine_entry(k);
    end

    state_t                                    state_q, state_d;
    logic [IDX_W-1:0]                          idx_q;
    logic                                      drain_q;
    logic [NUM_VOICES-1:0][LUT_ADDR_WIDTH-1:0] snap_addr_q;
    logic [NUM_VOICES-1:0]                     snap_gate_q;
    logic [LUT_ADDR_WIDTH-1:0]                 rom_addr_q;
    logic signed [SAMPLE_WIDTH-1:0]            rom_data_q;
    logic                                      vld_p1_q, vld_p2_q;
    logic                                      gate_p1_q, gate_p2_q;
    logic signed [ACC_W-1:0]                   acc_q, acc_d, addend, shifted;
    logic signed [SAMPLE_WIDTH-1:0]            mix_q, mix_d;
    logic                                      overrun_q;

    logic busy, mix_valid, issue, tick_accept, tick_drop, load_mix;

    // Only the LUT address bits of each phase matter; the rest are consumed here.
    logic unused_phase_bits;
    assign unused_phase_bits = ^bus.phase_value_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.sample_tick_in) state_d = S_RUN;
            S_RUN:   if (idx_q == IDX_LAST) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        mix_valid   = (state_q == S_OUT);
        issue       = (state_q == S_RUN);
        tick_accept = bus.sample_tick_in && (state_q == S_IDLE);
        tick_drop   = bus.sample_tick_in && (state_q != S_IDLE);
        load_mix    = (state_q == S_DRAIN) && drain_q;
    end

    // The final voice's ROM word lands in the last DRAIN cycle, so the result is taken from acc_d.
    always_comb begin
        addend = '0;
        if (vld_p2_q && gate_p2_q) addend = ACC_W'(rom_data_q);
        acc_d   = acc_q + addend;
        shifted = acc_d >>> MIX_SHIFT;
        if (shifted > SAT_MAX)      mix_d = SAMPLE_WIDTH'(SAT_MAX);
        else if (shifted < SAT_MIN) mix_d = SAMPLE_WIDTH'(SAT_MIN);
        else                        mix_d = SAMPLE_WIDTH'(shifted);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            idx_q       <= '0;
            drain_q     <= 1'b0;
            snap_addr_q <= '0;
            snap_gate_q <= '0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            gate_p1_q   <= 1'b0;
            gate_p2_q   <= 1'b0;
            acc_q       <= '0;
            mix_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (tick_accept) begin
                for (int v = 0; v < NUM_VOICES; v++)
                    snap_addr_q[v] <= bus.phase_value_in[v][PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
                snap_gate_q <= bus.gate_in;
                idx_q       <= '0;
                acc_q       <= '0;
            end else begin
                acc_q <= acc_d;
                if (issue) idx_q <= idx_q + 1'b1;
            end
            drain_q   <= (state_q == S_DRAIN) && !drain_q;
            vld_p1_q  <= issue;
            gate_p1_q <= issue && snap_gate_q[idx_q];
            vld_p2_q  <= vld_p1_q;
            gate_p2_q <= gate_p1_q;
            if (load_mix)  mix_q     <= mix_d;
            if (tick_drop) overrun_q <= 1'b1;
        end
    end

    // ROM address and data registers carry no reset so the pair maps onto block RAM.
    always_ff @(posedge clk_in) begin
        rom_addr_q <= snap_addr_q[idx_q];
        rom_data_q <= rom_w[rom_addr_q];
    end

    assign bus.mix_out       = mix_q;
    assign bus.mix_valid_out = mix_valid;
    assign bus.busy_out      = busy;
    assign bus.overrun_out   = overrun_q;
endmodule

// File: tb/tb_sine_voice_mixer.sv
// tb/tb_sine_voice_mixer.sv - directed-vector bench for sine_voice_mixer
module tb_sine_voice_mixer;
    localparam int NV = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sine_voice_mixer_if #(.NUM_VOICES(NV), .PHASE_WIDTH(32), .SAMPLE_WIDTH(16)) bus ();

    sine_voice_mixer #(
        .NUM_VOICES(NV), .PHASE_WIDTH(32), .LUT_ADDR_WIDTH(8), .SAMPLE_WIDTH(16), .MIX_SHIFT(3)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int extra       = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_voices(input logic [31:0] ph, input logic [NV-1:0] gates);
        for (int v = 0; v < NV; v++) bus.phase_value_in[v] = ph;
        bus.gate_in = gates;
    endtask

    // Leaves the bench at the negedge of cycle 1 of the new mix.
    task automatic do_tick();
        bus.sample_tick_in = 1'b1;
        step();
        bus.sample_tick_in = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_valid(input string tag, input logic signed [31:0] exp_mix);
        bit busy_ok;
        busy_ok = 1'b1;
        while (!bus.mix_valid_out && cyc < 60) begin
            if (!bus.busy_out) busy_ok = 1'b0;
            step();
        end
        check({tag, "_latency"}, cyc, 27);
        check({tag, "_mix"}, bus.mix_out, exp_mix);
        check({tag, "_busy"}, 32'(busy_ok && bus.busy_out), 1);
        step();
        check({tag, "_pulse_width"}, bus.mix_valid_out, 0);
        check({tag, "_busy_end"}, bus.busy_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.sample_tick_in = 1'b0;
        set_voices(32'h0, '0);
        repeat (3) @(negedge clk);
        check("reset_mix", bus.mix_out, 0);
        check("reset_valid", bus.mix_valid_out, 0);
        check("reset_busy", bus.busy_out, 0);
        check("reset_overrun", bus.overrun_out, 0);
        rst_n = 1'b1;
        step();

        set_voices(32'h0, '0);
        bus.phase_value_in[0] = 32'h4000_0000;
        bus.gate_in[0]        = 1'b1;
        do_tick();
        wait_valid("single_voice", 4095);

        set_voices(32'h4000_0000, '1);
        do_tick();
        wait_valid("all_pos_sat", 32767);

        set_voices(32'h0, '1);
        bus.phase_value_in[3] = 32'h4000_0000;
        bus.phase_value_in[7] = 32'hC000_0000;
        bus.gate_in[7]        = 1'b0;
        do_tick();
        wait_valid("gated_pair", 4095);

        set_voices(32'hC000_0000, '1);
        do_tick();
        wait_valid("all_neg_sat", -32768);

        set_voices(32'h0, '1);
        bus.phase_value_in[3] = 32'h4000_0000;
        bus.phase_value_in[7] = 32'hC000_0000;
        bus.gate_in[7]        = 1'b0;
        do_tick();
        step();
        set_voices(32'hC000_0000, '0);
        wait_valid("snapshot", 4095);
        check("no_overrun_yet", bus.overrun_out, 0);

        set_voices(32'h0, '0);
        bus.phase_value_in[0] = 32'h2000_0000;
        bus.gate_in[0]        = 1'b1;
        do_tick();
        while (cyc < 10) step();
        bus.sample_tick_in = 1'b1;
        step();
        bus.sample_tick_in = 1'b0;
        wait_valid("overrun_mix", 2896);
        check("overrun_set", bus.overrun_out, 1);
        extra = 0;
        repeat (40) begin
            step();
            if (bus.mix_valid_out) extra++;
        end
        check("overrun_single_pulse", extra, 0);
        check("overrun_sticky", bus.overrun_out, 1);

        set_voices(32'h4000_0000, '1);
        do_tick();
        while (cyc < 15) step();
        #1 rst_n = 1'b0;
        #1;
        check("midreset_mix", bus.mix_out, 0);
        check("midreset_valid", bus.mix_valid_out, 0);
        check("midreset_busy", bus.busy_out, 0);
        check("midreset_overrun", bus.overrun_out, 0);
        step();
        step();
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            step();
            if (bus.mix_valid_out) extra++;
        end
        check("midreset_no_pulse", extra, 0);

        set_voices(32'h0, '0);
        bus.phase_value_in[0] = 32'h4000_0000;
        bus.gate_in[0]        = 1'b1;
        do_tick();
        wait_valid("b2b_first", 4095);
        set_voices(32'h0, '0);
        bus.phase_value_in[5] = 32'hE000_0000;
        bus.gate_in[5]        = 1'b1;
        do_tick();
        wait_valid("b2b_second", -2897);
        check("b2b_no_overrun", bus.overrun_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
